csr_regfile: RTL
================

# csr_regfile

Parametrised, mask-driven CSR register file that generalises the core's fixed control-register block. Register count, per-bit access type (RW, RO, WO-pulse), reset values and busy-lock policy are all set by parameters. It adds byte strobes, an error response, and a response FIFO that holds multiple outstanding responses. It sits between the host CSR port and the core/instruction/AM control logic.

## Interface
- CsrDataWidth, 32: data width; multiple of 8.
- CsrAddrWidth, 32: request address width; address is the register word index.
- NumRegs, 16: number of registers.
- RspFifoDepth, 2: response FIFO entries; ≥1.
- RwMask, all-ones `[NumRegs-1:0][CsrDataWidth-1:0]`: RW bits.
- PulseMask, 0: WO bits that generate a one-cycle pulse; disjoint from RwMask.
- RoMask, 0: bits read from the hardware input `reg_ro_i`; disjoint from the other masks.
- ResetVal, 0: per-register reset value; applies to RW bits only.
- LockMask, 0 `[NumRegs-1:0]`: register is write-locked while `csr_busy_i` is high.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- csr_req_data_i  in  CsrDataWidth  write data.
- csr_req_strb_i  in  CsrDataWidth/8  byte enables for writes.
- csr_req_addr_i  in  CsrAddrWidth  register index.
- csr_req_write_i  in  1  1 = write, 0 = read.
- csr_req_valid_i  in  1  request valid.
- csr_req_ready_o  out  1  request ready.
- csr_rsp_data_o  out  CsrDataWidth  response data.
- csr_rsp_err_o  out  1  response error.
- csr_rsp_valid_o  out  1  response valid.
- csr_rsp_ready_i  in  1  response ready.
- csr_busy_i  in  1  core busy; gates writes to locked registers.
- reg_q_o  out  NumRegs×CsrDataWidth  RW register contents; non-RW bits read 0.
- reg_pulse_o  out  NumRegs×CsrDataWidth  WO pulses.
- reg_wr_o  out  NumRegs  one-hot write strobe for an accepted, non-error write.
- reg_ro_i  in  NumRegs×CsrDataWidth  RO status inputs.

## Operation
- Handshake:
  - Accept = `csr_req_valid_i & csr_req_ready_o`.
  - `csr_req_ready_o` = FIFO count < RspFifoDepth. It is combinational on the count only, never on valid.
- Every accepted request, read or write, pushes exactly one response. Write responses carry data 0.
- Error conditions, each giving err=1 and data 0:
  - addr ≥ NumRegs;
  - write to a register with LockMask set while `csr_busy_i`=1 at the accept cycle.
- An erroneous write changes no state, raises no pulse and no `reg_wr_o`.
- Write, per bit b of byte k with `strb[k]`=1:
  - RW bit: reg ← data.
  - Pulse bit: `reg_pulse_o` bit = data in the accept cycle only (combinational); 0 otherwise.
  - RO bit: ignored.
- Bytes with strb=0 are untouched and do not pulse. An all-zero strobe is a legal no-op write: no error, and `reg_wr_o` still fires.
- Read data, sampled at the accept cycle = (reg & RwMask) | (reg_ro_i & RoMask). Pulse bits read 0. Strobe is ignored.
- Read-after-write: a read accepted in the cycle after a write returns the new value.
- Response FIFO:
  - Order: first in, first out.
  - Pop = `csr_rsp_valid_o & csr_rsp_ready_i`.
  - Push and pop in the same cycle keep the count unchanged.
  - When full, ready=0; a pop in that cycle makes ready=1 on the next cycle (no same-cycle pass-through).
- Reset mid-operation: the FIFO is flushed; outstanding responses are lost.

## Timing
- Reset values:
  - `reg_q_o` = ResetVal & RwMask.
  - `reg_pulse_o` = 0; `reg_wr_o` = 0.
  - `csr_rsp_valid_o` = 0, `csr_rsp_data_o` = 0, `csr_rsp_err_o` = 0.
  - `csr_req_ready_o` = 1.
- Write state (`reg_q_o`) updates on the clock edge after accept.
- `reg_pulse_o` and `reg_wr_o` are asserted combinationally in the accept cycle, for exactly one cycle.
- Response latency: `csr_rsp_valid_o` rises on the cycle after accept. Data/err come from registered FIFO head storage.
- Throughput with `csr_rsp_ready_i` held at 1: one request per cycle sustained.
- With `csr_rsp_ready_i`=0: exactly RspFifoDepth requests are accepted, then ready=0.
- Response outputs are held stable while valid=1 and ready=0. When the FIFO is empty, data and err return to 0.

## Test plan
- Reset → ready=1, rsp_valid=0, `reg_q_o`[i]=ResetVal[i]&RwMask[i]. Write 0xDEADBEEF to reg 3 (all RW), strb=0xF, then read → rsp err=0, data 0xDEADBEEF one cycle after read accept.
- Byte strobe: reg 3 = 0xDEADBEEF; write 0x11223344 with strb=0x5 → read 0xDE22BE44.
- Mixed masks, reg 0 with RwMask=0x3C, PulseMask=0x3, RoMask=0xC0 and `reg_ro_i`[0]=0x80:
  - write 0xFF → pulse bits 0x3 high one cycle, `reg_wr_o`[0]=1;
  - read → 0xBC.
- Errors:
  - read addr NumRegs → err=1, data 0.
  - LockMask[2]=1 with busy=1, write reg 2 → err=1, reg unchanged, no `reg_wr_o`.
  - Same write with busy=0 → err=0, value updated.
- Backpressure, RspFifoDepth=2, `csr_rsp_ready_i`=0: issue 3 reads → 2 accepted, ready=0. Raise rsp_ready → responses drain in order, and the third is accepted the cycle after the first pop.
- Assert rst_ni with 2 responses pending → valid=0 immediately (async), ready=1, registers back at ResetVal.

Source files
------------

// File: rtl/csr_regfile.sv
// csr_regfile: mask-driven CSR register file with byte strobes, lock errors and a response FIFO
module csr_regfile #(
  parameter int unsigned CsrDataWidth = 32,
  parameter int unsigned CsrAddrWidth = 32,
  parameter int unsigned NumRegs      = 16,
  parameter int unsigned RspFifoDepth = 2,
  parameter logic [NumRegs-1:0][CsrDataWidth-1:0] RwMask    = '1,
  parameter logic [NumRegs-1:0][CsrDataWidth-1:0] PulseMask = '0,
  parameter logic [NumRegs-1:0][CsrDataWidth-1:0] RoMask    = '0,
  parameter logic [NumRegs-1:0][CsrDataWidth-1:0] ResetVal  = '0,
  parameter logic [NumRegs-1:0]                   LockMask  = '0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [CsrDataWidth-1:0]                csr_req_data_i,
  input  logic [CsrDataWidth/8-1:0]              csr_req_strb_i,
  input  logic [CsrAddrWidth-1:0]                csr_req_addr_i,
  input  logic                                   csr_req_write_i,
  input  logic                                   csr_req_valid_i,
  output logic                                   csr_req_ready_o,
  output logic [CsrDataWidth-1:0]                csr_rsp_data_o,
  output logic                                   csr_rsp_err_o,
  output logic                                   csr_rsp_valid_o,
  input  logic                                   csr_rsp_ready_i,
  input  logic                                   csr_busy_i,
  output logic [NumRegs-1:0][CsrDataWidth-1:0]   reg_q_o,
  output logic [NumRegs-1:0][CsrDataWidth-1:0]   reg_pulse_o,
  output logic [NumRegs-1:0]                     reg_wr_o,
  input  logic [NumRegs-1:0][CsrDataWidth-1:0]   reg_ro_i
);

  localparam int unsigned PtrW = RspFifoDepth > 1 ? $clog2(RspFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(RspFifoDepth + 1);

  logic [NumRegs-1:0][CsrDataWidth-1:0]  reg_q, reg_d;
  logic [RspFifoDepth-1:0][CsrDataWidth:0] mem_q, mem_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CsrDataWidth-1:0] bmask, rd_data, push_data;
  logic [NumRegs-1:0]      hit, wr_hit;
  logic                    accept, err, locked, wr_ok, pop;

  assign csr_req_ready_o = cnt_q < CntW'(RspFifoDepth);
  assign accept          = csr_req_valid_i & csr_req_ready_o;
  assign locked          = csr_req_write_i & csr_busy_i & |(hit & LockMask);
  assign err             = ~(|hit) | locked;
  assign wr_ok           = accept & csr_req_write_i & ~err;
  assign wr_hit          = hit & {NumRegs{wr_ok}};
  assign push_data       = (csr_req_write_i | err) ? '0 : rd_data;
  assign pop             = csr_rsp_valid_o & csr_rsp_ready_i;
  assign csr_rsp_valid_o = cnt_q != '0;
  assign csr_rsp_data_o  = csr_rsp_valid_o ? mem_q[rd_ptr_q][CsrDataWidth-1:0] : '0;
  assign csr_rsp_err_o   = csr_rsp_valid_o & mem_q[rd_ptr_q][CsrDataWidth];
  assign reg_q_o         = reg_q;
  assign reg_wr_o        = wr_hit;

  // Address decode, byte-strobe expansion and read-data mux
  always_comb begin
    bmask = '0;
    hit = '0;
    rd_data = '0;
    for (int b = 0; b < CsrDataWidth; b++) bmask[b] = csr_req_strb_i[b/8];
    for (int i = 0; i < NumRegs; i++) begin
      hit[i] = csr_req_addr_i == CsrAddrWidth'(i);
      rd_data |= hit[i] ? ((reg_q[i] & RwMask[i]) | (reg_ro_i[i] & RoMask[i])) : '0;
    end
  end

  // Strobed update of RW bits and combinational write pulses
  always_comb begin
    reg_d = reg_q;
    reg_pulse_o = '0;
    for (int i = 0; i < NumRegs; i++) begin
      reg_d[i] = wr_hit[i] ? (reg_q[i] & ~(bmask & RwMask[i])) | (csr_req_data_i & bmask & RwMask[i]) : reg_q[i];
      reg_pulse_o[i] = wr_hit[i] ? (csr_req_data_i & bmask & PulseMask[i]) : '0;
    end
  end

  // Response FIFO next state; a full FIFO never accepts, so push implies space
  always_comb begin
    mem_d = mem_q;
    if (accept) mem_d[wr_ptr_q] = {err, push_data};
    wr_ptr_d = accept ? ((wr_ptr_q == PtrW'(RspFifoDepth - 1)) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = pop ? ((rd_ptr_q == PtrW'(RspFifoDepth - 1)) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    cnt_d = cnt_q + CntW'(accept) - CntW'(pop);
  end

  // State registers; reset flushes any outstanding responses
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_q    <= ResetVal & RwMask;
      mem_q    <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      reg_q    <= reg_d;
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule
